// File: rtl/rf_access_arbiter.sv
// Two-requester arbiter in front of a 4-entry register file plus accumulator.
// Round-robin by default; define RF_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module rf_access_arbiter #(
  parameter int DW = 8
) (
  input  logic          Reg_clk,
  input  logic          Reg_rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic          acc0,
  input  logic          acc1,
  input  logic [1:0]    sel0,
  input  logic [1:0]    sel1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] rf_data_out,
  input  logic [DW-1:0] rf_acc_out,
  output logic [1:0]    select,
  output logic          RF_we,
  output logic          Acc_we,
  output logic [DW-1:0] data_in,
  output logic [DW-1:0] Acc_in,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          wr_q, wr_d;
  logic          acc_q, acc_d;
  logic [1:0]    select_q, select_d;
  logic [DW-1:0] data_in_q, data_in_d;
  logic [DW-1:0] acc_in_q, acc_in_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          win1;

`ifdef RF_ARB_FIXED_PRIO_EN
  // Requester 0 always wins; requester 1 only when alone.
  always_comb begin
    win1 = ~req0;
  end
`else
  logic last_q, last_d;

  // On contention the requester not granted last time wins.
  always_comb begin
    win1 = (req0 && req1) ? ~last_q : req1;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE && (req0 || req1)) begin
      last_d = win1;
    end
  end

  always_ff @(posedge Reg_clk or negedge Reg_rst_n) begin
    if (!Reg_rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    wr_d      = wr_q;
    acc_d     = acc_q;
    select_d  = select_q;
    data_in_d = data_in_q;
    acc_in_d  = acc_in_q;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          gnt_d     = win1;
          wr_d      = win1 ? wr1 : wr0;
          acc_d     = win1 ? acc1 : acc0;
          select_d  = win1 ? sel1 : sel0;
          data_in_d = win1 ? wdata1 : wdata0;
          acc_in_d  = win1 ? wdata1 : wdata0;
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!wr_q) begin
          rdata_d = acc_q ? rf_acc_out : rf_data_out;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Reg_clk or negedge Reg_rst_n) begin
    if (!Reg_rst_n) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      wr_q      <= 1'b0;
      acc_q     <= 1'b0;
      select_q  <= 2'b00;
      data_in_q <= '0;
      acc_in_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      wr_q      <= wr_d;
      acc_q     <= acc_d;
      select_q  <= select_d;
      data_in_q <= data_in_d;
      acc_in_q  <= acc_in_d;
      rdata_q   <= rdata_d;
    end
  end

  // Enables and done decode straight from state so an async reset kills them at once.
  assign RF_we   = (state_q == ST_ACCESS) && wr_q && !acc_q;
  assign Acc_we  = (state_q == ST_ACCESS) && wr_q && acc_q;
  assign done0   = (state_q == ST_RESP) && !gnt_q;
  assign done1   = (state_q == ST_RESP) && gnt_q;
  assign busy    = (state_q != ST_IDLE);
  assign select  = select_q;
  assign data_in = data_in_q;
  assign Acc_in  = acc_in_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Scoreboard bench for rf_access_arbiter: a behavioural register file answers the DUT,
// expected transactions are queued when issued and retired on each done pulse.
module tb_rf_access_arbiter;

  logic       Reg_clk = 1'b0;
  logic       Reg_rst_n = 1'b0;
  logic       req0 = 0, req1 = 0, wr0 = 0, wr1 = 0, acc0 = 0, acc1 = 0;
  logic [1:0] sel0 = 0, sel1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic [7:0] rf_data_out, rf_acc_out;
  logic [1:0] select;
  logic       RF_we, Acc_we, done0, done1, busy;
  logic [7:0] data_in, Acc_in, rdata;

  always #5 Reg_clk = ~Reg_clk;

  rf_access_arbiter #(.DW(8)) dut (
    .Reg_clk(Reg_clk), .Reg_rst_n(Reg_rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1), .acc0(acc0), .acc1(acc1),
    .sel0(sel0), .sel1(sel1), .wdata0(wdata0), .wdata1(wdata1),
    .rf_data_out(rf_data_out), .rf_acc_out(rf_acc_out),
    .select(select), .RF_we(RF_we), .Acc_we(Acc_we),
    .data_in(data_in), .Acc_in(Acc_in), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy)
  );

  // Register file environment, driven only by the DUT's enables.
  logic [7:0] rf_mem [4] = '{default: 8'h00};
  logic [7:0] rf_acc = 8'h00;
  always @(posedge Reg_clk) begin
    if (RF_we)  rf_mem[select] <= data_in;
    if (Acc_we) rf_acc <= Acc_in;
  end
  assign rf_data_out = rf_mem[select];
  assign rf_acc_out  = rf_acc;

  typedef struct {
    logic       id;
    logic       wr;
    logic       acc;
    logic [1:0] sel;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] mdl_mem [4] = '{default: 8'h00};
  logic [7:0] mdl_acc = 8'h00;
  logic       mdl_last = 1'b1;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;

  always @(posedge Reg_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input logic id, input logic wr, input logic acc,
                          input logic [1:0] sel, input logic [7:0] wd);
    exp_t e;
    e.id = id; e.wr = wr; e.acc = acc; e.sel = sel; e.wdata = wd;
    e.rdata = acc ? mdl_acc : mdl_mem[sel];
    if (wr) begin
      if (acc) mdl_acc = wd;
      else     mdl_mem[sel] = wd;
    end
    mdl_last = id;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic id, input logic r, input logic wr, input logic acc,
                       input logic [1:0] sel, input logic [7:0] wd);
    if (!id) begin
      req0 = r; wr0 = wr; acc0 = acc; sel0 = sel; wdata0 = wd;
    end else begin
      req1 = r; wr1 = wr; acc1 = acc; sel1 = sel; wdata1 = wd;
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_select"}, select, 0);
    chk({pfx, "_we"}, {RF_we, Acc_we}, 0);
    chk({pfx, "_data_in"}, data_in, 0);
    chk({pfx, "_acc_in"}, Acc_in, 0);
    chk({pfx, "_done"}, {done0, done1}, 0);
    chk({pfx, "_rdata"}, rdata, 0);
    chk({pfx, "_busy"}, busy, 0);
  endtask

  // Snapshot of the previous cycle (the ACCESS cycle when done is seen).
  logic       p_rf_we = 0, p_acc_we = 0, p_busy = 0;
  logic [1:0] p_sel = 0;
  logic [7:0] p_din = 0, p_ain = 0;

  always @(negedge Reg_clk) begin
    if (done0 || done1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", {done0, done1}, 0);
      end else begin
        chk("done_id", done1, sb_q[0].id);
        chk("done_onehot", done0 & done1, 0);
        chk("access_busy", p_busy, 1);
        chk("we_in_resp", {RF_we, Acc_we}, 0);
        chk("we_excl", p_rf_we & p_acc_we, 0);
        chk("rf_we", p_rf_we, sb_q[0].wr & ~sb_q[0].acc);
        chk("acc_we", p_acc_we, sb_q[0].wr & sb_q[0].acc);
        if (!sb_q[0].acc) chk("select", p_sel, sb_q[0].sel);
        if (sb_q[0].wr && !sb_q[0].acc) chk("data_in", p_din, sb_q[0].wdata);
        if (sb_q[0].wr && sb_q[0].acc) chk("acc_in", p_ain, sb_q[0].wdata);
        if (!sb_q[0].wr) chk("rdata", rdata, sb_q[0].rdata);
        void'(sb_q.pop_front());
      end
    end
    p_rf_we  <= RF_we;
    p_acc_we <= Acc_we;
    p_busy   <= busy;
    p_sel    <= select;
    p_din    <= data_in;
    p_ain    <= Acc_in;
  end

  task automatic run_single(input logic id, input logic wr, input logic acc,
                            input logic [1:0] sel, input logic [7:0] wd);
    int  t0;
    bit  got;
    int  t_done;
    @(negedge Reg_clk);
    drive(id, 1'b1, wr, acc, sel, wd);
    push_exp(id, wr, acc, sel, wd);
    t0 = cyc;
    got = 0;
    t_done = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Reg_clk);
      if (id ? done1 : done0) begin
        got = 1;
        t_done = cyc;
      end
    end
    chk("done_timeout", got, 1);
    if (got) chk("latency", t_done - t0, 2);
    drive(id, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
  endtask

  initial begin
    int  n_done;
    int  last_cyc;
    bit  seen;
    logic w;

    #3;
    chk_reset_vals("rst");
    @(negedge Reg_clk);
    Reg_rst_n = 1'b1;

    run_single(1'b0, 1'b1, 1'b0, 2'd2, 8'h5A);   // write C
    run_single(1'b1, 1'b0, 1'b0, 2'd2, 8'h00);   // read C
    run_single(1'b1, 1'b1, 1'b1, 2'd0, 8'h3C);   // acc write
    run_single(1'b0, 1'b0, 1'b1, 2'd1, 8'h00);   // acc read
    run_single(1'b1, 1'b1, 1'b0, 2'd3, 8'hC3);   // requester 1 twice in a row
    run_single(1'b1, 1'b0, 1'b0, 2'd3, 8'h00);
    run_single(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);   // read untouched A

    // Reset pulse in the ACCESS cycle of a write.
    @(negedge Reg_clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 8'hA5);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge Reg_clk);
      if (RF_we) seen = 1;
    end
    chk("rst_access_reached", seen, 1);
    #1 Reg_rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    mdl_last = 1'b1;
    #1 Reg_rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Reg_clk);
      if (done0 || done1 || busy) seen = 1;
    end
    chk("no_done_after_rst", seen, 0);
    chk("aborted_write_not_committed", rf_mem[3], mdl_mem[3]);

    // Both requesters held continuously.
    @(negedge Reg_clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h11);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 8'h22);
    for (int k = 0; k < 4; k++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      w = 1'b0;
`else
      w = ~mdl_last;
`endif
      push_exp(w, 1'b1, 1'b0, w ? 2'd1 : 2'd0, w ? 8'h22 : 8'h11);
    end
    n_done = 0;
    last_cyc = 0;
    for (int i = 0; i < 60 && n_done < 4; i++) begin
      @(negedge Reg_clk);
      if (done0 || done1) begin
        n_done++;
        if (n_done > 1) chk("done_spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
        if (n_done == 4) begin
          drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
          drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        end
      end
    end
    chk("contend_done_count", n_done, 4);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);

    run_single(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);   // read A
    run_single(1'b1, 1'b0, 1'b0, 2'd1, 8'h00);   // read B

    repeat (3) @(negedge Reg_clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
